// File: rtl/add16_nibble_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that time-shares one external 4-bit CLA slice,
// one nibble per cycle LSB first, with carry chained through a 1-bit register.
module add16_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    // dbg_state encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic [WIDTH-1:0] fin;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and once out_valid rises the result is held
    // unchanged until the edge on which out_ready completes the transfer.
    assign in_ready  = (state == IDLE) & ~rst;
    assign dbg_state = state;

    // Full result as it will look after the last nibble lands; only used on that edge.
    always_comb begin
        fin                 = acc;
        fin[WIDTH-1 -: 4]   = slice_sum;
    end

    always_comb begin
        slice_a   = 4'd0;
        slice_b   = 4'd0;
        slice_cin = 1'b0;
        if (state == RUN) begin
            slice_a   = opa[4*idx +: 4];
            slice_b   = opb[4*idx +: 4];
            slice_cin = cy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            cy        <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b ^ {WIDTH{op_sub}};
                        cy    <= op_sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc[4*idx +: 4] <= slice_sum;
                    cy              <= slice_cout;
                    idx             <= idx + 1'b1;
                    if (idx == IW'(NIB - 1)) begin
                        idx       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= fin;
                        carry     <= slice_cout;
                        overflow  <= (opa[WIDTH-1] == opb[WIDTH-1]) &
                                     (fin[WIDTH-1] != opa[WIDTH-1]);
                        zero      <= (fin == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add16_nibble_sequencer.sv
// Self-checking bench for add16_nibble_sequencer: a 4-bit CLA slice model, directed
// operations with literal expectations, and an arithmetic reference model scoreboard.
module tb_add16_nibble_sequencer;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_sub;
    logic [3:0]   slice_a;
    logic [3:0]   slice_b;
    logic         slice_cin;
    logic [3:0]   slice_sum;
    logic         slice_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    add16_nibble_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op_sub     (op_sub),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .carry      (carry),
        .overflow   (overflow),
        .zero       (zero),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4-bit carry-lookahead slice ----------------
    logic [3:0] g, p;
    logic [4:0] c;
    always_comb begin
        g    = slice_a & slice_b;
        p    = slice_a ^ slice_b;
        c[0] = slice_cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
               (p[3] & p[2] & p[1] & p[0] & c[0]);
        slice_sum  = p ^ c[3:0];
        slice_cout = c[4];
    end

    // ---------------- checking helpers ----------------
    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Reference: plain unsigned/signed arithmetic. Returns {carry, overflow, zero, sum}.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        int ux, uy, sx, sy, sr;
        logic [W-1:0] r;
        logic cf, vf;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        if (s) begin
            r  = W'(ux - uy);
            cf = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = W'(ux + uy);
            cf = (ux + uy) > 65535;
            sr = sx + sy;
        end
        vf = (sr > 32767) || (sr < -32768);
        return {cf, vf, (r == '0), r};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W+2:0] exp_q[$];
    int  cyc      = 0;
    int  acc_cyc  = 0;
    int  last_acc = -1;
    bit  b2b      = 1'b0;
    logic prev_ov = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, op_sub));
                acc_cyc <= cyc + 1;
                if (b2b && last_acc >= 0)
                    check("accept_spacing", 32'(cyc - last_acc), 32'd6);
                last_acc <= cyc;
            end
            if (out_valid && out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
        end
        if (!b2b)
            last_acc <= -1;
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                check("model_sum",      32'(sum),      32'(exp_q[0][W-1:0]));
                check("model_carry",    32'(carry),    32'(exp_q[0][W+2]));
                check("model_overflow", 32'(overflow), 32'(exp_q[0][W+1]));
                check("model_zero",     32'(zero),     32'(exp_q[0][W]));
            end
            if (!prev_ov)
                check("latency_edges", 32'(cyc - acc_cyc), 32'd4);
        end
        prev_ov <= out_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #2;
        end
        if (!got)
            check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Issues one operation and checks its slice traffic and result against literals.
    // Returns at posedge+2 after the handshake, or at the result negedge if out_ready is low.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [W-1:0] es, input logic ec, input logic ev,
                         input logic ez);
        bit got;
        logic [W-1:0] ye;
        ye       = s ? ~y : y;
        a        = x;
        b        = y;
        op_sub   = s;
        in_valid = 1'b1;
        wait_accept(got);
        in_valid = 1'b0;
        if (!got) return;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("slice_a", 32'(slice_a), 32'(x[4*k +: 4]));
            check("slice_b", 32'(slice_b), 32'(ye[4*k +: 4]));
            if (k == 0)
                check("slice_cin0", 32'(slice_cin), 32'(s));
        end
        @(negedge clk);
        check("lit_out_valid", 32'(out_valid), 32'd1);
        check("lit_sum",       32'(sum),       32'(es));
        check("lit_flags",     {29'd0, carry, overflow, zero}, {29'd0, ec, ev, ez});
        if (out_ready) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic [W-1:0] es;
        logic         ec, ev, ez;
    } vec_t;

    vec_t dir_vecs[6] = '{
        '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
        '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0},
        '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0}
    };

    vec_t b2b_vecs[3] = '{
        '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0},
        '{16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4B, 1'b1, 1'b1, 1'b0},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1}
    };

    initial begin
        bit got;
        logic [W+2:0] m;
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h1111;
        op_sub    = 1'b0;
        out_ready = 1'b1;

        // Model pinned against hand-computed literals.
        m = model(16'h1234, 16'h4321, 1'b0);
        check("pin_add",  32'(m), 32'({1'b0, 1'b0, 1'b0, 16'h5555}));
        m = model(16'h8000, 16'h0001, 1'b1);
        check("pin_sub_ov", 32'(m), 32'({1'b1, 1'b1, 1'b0, 16'h7FFF}));

        // Reset with in_valid high: nothing may be accepted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_state",     32'(dbg_state), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_flags",     {29'd0, carry, overflow, zero}, 32'd0);
        check("rst_slice",     {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // Directed single operations.
        foreach (dir_vecs[i])
            do_op(dir_vecs[i].x, dir_vecs[i].y, dir_vecs[i].s,
                  dir_vecs[i].es, dir_vecs[i].ec, dir_vecs[i].ev, dir_vecs[i].ez);

        // Backpressure with ignored operand pulses.
        out_ready = 1'b0;
        do_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            a        = W'($urandom_range(0, 65535));
            b        = W'($urandom_range(0, 65535));
            op_sub   = 1'(k);
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_sum",       32'(sum),       32'h3333);
            check("bp_flags",     {29'd0, carry, overflow, zero}, 32'd0);
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_state", 32'(dbg_state), 32'd0);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_hold_sum",      32'(sum),       32'h3333);
        repeat (2) @(negedge clk);
        check("bp_no_spurious",   32'(out_valid), 32'd0);

        // Reset in the middle of RUN, at idx 2.
        @(posedge clk);
        #2;
        a        = 16'h1234;
        b        = 16'h0001;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        wait_accept(got);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_run_slice_a", 32'(slice_a), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_state",     32'(dbg_state), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",       32'(sum),       32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #2;
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        b2b      = 1'b1;
        in_valid = 1'b1;
        foreach (b2b_vecs[i]) begin
            a      = b2b_vecs[i].x;
            b      = b2b_vecs[i].y;
            op_sub = b2b_vecs[i].s;
            wait_accept(got);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        b2b = 1'b0;
        check("b2b_last_sum", 32'(sum), 32'h0000);
        check("b2b_last_flags", {29'd0, carry, overflow, zero}, 32'd7);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1);
    end

endmodule

// File: doc/add16_nibble_sequencer.md
# add16_nibble_sequencer

Multi-cycle 16-bit add/subtract controller that time-shares one external 4-bit carry-lookahead adder slice. It performs one nibble per cycle, least significant first, and chains the carry through an internal register. Results are returned with carry, overflow and zero flags. It sits beside the ALU as the area-reduced arithmetic path and uses valid/ready handshakes on both the operand side and the result side.

## Interface
- WIDTH, 16: operand width; must be a multiple of 4.
- NIB, WIDTH/4: number of slice passes (local parameter, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE with rst low.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op_sub  in  1  0 = A+B, 1 = A−B.
- slice_a  out  4  nibble of A to the CLA slice.
- slice_b  out  4  nibble of effective B to the CLA slice.
- slice_cin  out  1  carry into the slice.
- slice_sum  in  4  slice sum (combinational return).
- slice_cout  in  1  slice carry out.
- out_valid  out  1  result available.
- out_ready  in  1  result consumer accepts.
- sum  out  WIDTH  result.
- carry  out  1  final carry out (for subtract, 1 = no borrow).
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready = 1.
  - When in_valid & in_ready at an edge: capture opA = a, opB = b ^ {WIDTH{op_sub}}, carry register = op_sub, idx = 0.
  - Go to RUN.
- RUN
  - slice_a = opA[4*idx+3:4*idx], slice_b = opB[4*idx+3:4*idx], slice_cin = carry register.
  - Each edge:
    - sum[4*idx+3:4*idx] <= slice_sum.
    - carry register <= slice_cout.
    - idx++.
  - At idx == NIB−1, go to DONE.
  - On that same edge, register the flags:
    - carry = slice_cout.
    - overflow = (opA[MSB] == opB[MSB]) & (final sum[MSB] != opA[MSB]).
    - zero = (final sum == 0).
- DONE
  - out_valid = 1; sum and flags are held stable.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. No operation overlaps another.
- slice_a, slice_b and slice_cin are driven 0 outside RUN.
- sum and the flags keep their last values after the handshake, until the next completion overwrites them.
- Arithmetic is modulo 2^WIDTH. There is no wider intermediate; the carry register is 1 bit.

## Timing
- Reset values:
  - state = IDLE, idx = 0.
  - sum = 0, carry = 0, overflow = 0, zero = 0.
  - out_valid = 0.
  - slice_a = 0, slice_b = 0, slice_cin = 0.
  - in_ready = 0 while rst is high, 1 on the first cycle after reset.
- Latency: operand accepted at edge E0; nibbles captured at edges E1..E4; out_valid is high in the cycle after E4.
- If out_ready is high in that cycle, the state is IDLE after E5 and the next accept is at E6 at the earliest. Peak throughput is one operation per 6 cycles.
- The slice is purely combinational: slice_sum and slice_cout are sampled at the same edge that ends the RUN cycle presenting their inputs.
- Backpressure: out_valid stays high, and sum and the flags do not change, for as long as out_ready is low.
- rst in any state: IDLE on that edge.
  - out_valid drops.
  - A partially computed result is discarded.
  - The sum register is cleared to 0.
- rst and in_valid together: reset wins; nothing is accepted.

## Test plan
- Add 0x1234 + 0x4321 -> sum 0x5555, carry 0, overflow 0, zero 0. out_valid exactly 4 edges after the accept edge; slice_a steps through 4, 3, 2, 1 on successive RUN cycles.
- Add 0xFFFF + 0x0001 -> sum 0x0000, carry 1, zero 1, overflow 0. Add 0x7FFF + 0x0001 -> sum 0x8000, overflow 1, carry 0.
- Subtract 0x0005 − 0x0005 -> sum 0x0000, carry 1, zero 1. Subtract 0x8000 − 0x0001 -> sum 0x7FFF, overflow 1, carry 1. Subtract 0x0000 − 0x0001 -> sum 0xFFFF, carry 0.
- Backpressure: hold out_ready low for 3 cycles after out_valid rises, while pulsing in_valid with other operands -> sum and flags stable, in_ready 0, the pulsed operands are not accepted. Then release out_ready -> IDLE next edge.
- Reset during RUN at idx == 2 -> next cycle: state IDLE, out_valid 0, sum 0, in_ready 1. A following 0x0001 + 0x0001 returns 0x0002 with correct latency.
- Back-to-back: in_valid and out_ready held high over 3 operations -> accepts spaced exactly 6 cycles apart, each result correct. The bench instantiates the 4-bit CLA as the slice model.
